pwm_duty_ramp: RTL and testbench



---
 rtl/pwm_duty_ramp.sv | 132 +++++++++++++
 tb/tb_pwm_duty_ramp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Slew-limited duty command stage feeding the PWM generator request input.
// Optional emergency stop enabled by defining DUTY_RAMP_ESTOP_EN.
module pwm_duty_ramp #(
  parameter int MAX_DUTY    = 250,
  parameter int TICK_CYCLES = 2500,
  parameter int STEP        = 1
) (
  input  logic       clock,
  input  logic       reset,
`ifdef DUTY_RAMP_ESTOP_EN
  input  logic       estop,
`endif
  input  logic       cmd_valid,
  input  logic [7:0] cmd_duty,
  output logic       cmd_ready,
  output logic [7:0] duty_out,
  output logic       busy,
  output logic       at_target,
  output logic       clamped
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [8:0] STEP_W = 9'(STEP);
  localparam logic [7:0] MAX_W  = 8'(MAX_DUTY);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

  state_t           state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic             tick;
  logic [7:0]       duty_r, duty_nxt;
  logic [7:0]       target_r, target_nxt;
  logic             clamped_r, clamped_nxt;
  logic             busy_r, at_target_r;
  logic             accept;
  logic             stop;

  // Saturating steps: 9-bit sum/difference, never past the target.
  function automatic logic [7:0] step_up(input logic [7:0] d, input logic [7:0] t);
    logic [8:0] sum;
    sum = {1'b0, d} + STEP_W;
    return (sum >= {1'b0, t}) ? t : sum[7:0];
  endfunction

  function automatic logic [7:0] step_down(input logic [7:0] d, input logic [7:0] t);
    logic signed [8:0] diff;
    diff = $signed({1'b0, d}) - $signed(STEP_W);
    return (diff <= $signed({1'b0, t})) ? t : diff[7:0];
  endfunction

`ifdef DUTY_RAMP_ESTOP_EN
  logic cmd_ready_r;
  assign stop = estop;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cmd_ready_r <= 1'b1;
    else       cmd_ready_r <= ~estop;
  end
  assign cmd_ready = cmd_ready_r;
`else
  assign stop      = 1'b0;
  assign cmd_ready = 1'b1;
`endif

  assign tick   = (cnt_r == CNT_LAST);
  assign accept = cmd_valid & cmd_ready & ~stop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     cnt_r <= '0;
    else if (tick) cnt_r <= '0;
    else           cnt_r <= cnt_r + 1'b1;
  end

  // Ramp decisions use the registered target; a new command lands next cycle.
  always_comb begin
    state_nxt   = state_r;
    duty_nxt    = duty_r;
    target_nxt  = target_r;
    clamped_nxt = clamped_r;

    if (target_r == duty_r) begin
      state_nxt = IDLE;
    end else if (target_r > duty_r) begin
      state_nxt = RAMP_UP;
      if (state_r != RAMP_DOWN && tick) begin
        duty_nxt = step_up(duty_r, target_r);
        if (duty_nxt == target_r) state_nxt = IDLE;
      end
    end else begin
      state_nxt = RAMP_DOWN;
      if (state_r != RAMP_UP && tick) begin
        duty_nxt = step_down(duty_r, target_r);
        if (duty_nxt == target_r) state_nxt = IDLE;
      end
    end

    if (accept) begin
      target_nxt  = (cmd_duty > MAX_W) ? MAX_W : cmd_duty;
      clamped_nxt = (cmd_duty > MAX_W);
    end

    if (stop) begin
      duty_nxt   = '0;
      target_nxt = '0;
      state_nxt  = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      duty_r      <= '0;
      target_r    <= '0;
      clamped_r   <= 1'b0;
      busy_r      <= 1'b0;
      at_target_r <= 1'b1;
    end else begin
      state_r     <= state_nxt;
      duty_r      <= duty_nxt;
      target_r    <= target_nxt;
      clamped_r   <= clamped_nxt;
      busy_r      <= (state_nxt != IDLE);
      at_target_r <= (duty_nxt == target_nxt);
    end
  end

  assign duty_out  = duty_r;
  assign busy      = busy_r;
  assign at_target = at_target_r;
  assign clamped   = clamped_r;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: STEP=10 instance (a) and STEP=50 instance (b), TICK_CYCLES=4.
module tb_pwm_duty_ramp;

  logic       clock;
  logic       reset;
  logic       estop;
  logic       cmd_valid_a, cmd_valid_b;
  logic [7:0] cmd_duty_a, cmd_duty_b;
  logic       cmd_ready_a, cmd_ready_b;
  logic [7:0] duty_a, duty_b;
  logic       busy_a, busy_b;
  logic       at_a, at_b;
  logic       clamped_a, clamped_b;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  pwm_duty_ramp #(.MAX_DUTY(250), .TICK_CYCLES(4), .STEP(10)) dut_a (
    .clock     (clock),
    .reset     (reset),
`ifdef DUTY_RAMP_ESTOP_EN
    .estop     (estop),
`endif
    .cmd_valid (cmd_valid_a),
    .cmd_duty  (cmd_duty_a),
    .cmd_ready (cmd_ready_a),
    .duty_out  (duty_a),
    .busy      (busy_a),
    .at_target (at_a),
    .clamped   (clamped_a)
  );

  pwm_duty_ramp #(.MAX_DUTY(250), .TICK_CYCLES(4), .STEP(50)) dut_b (
    .clock     (clock),
    .reset     (reset),
`ifdef DUTY_RAMP_ESTOP_EN
    .estop     (estop),
`endif
    .cmd_valid (cmd_valid_b),
    .cmd_duty  (cmd_duty_b),
    .cmd_ready (cmd_ready_b),
    .duty_out  (duty_b),
    .busy      (busy_b),
    .at_target (at_b),
    .clamped   (clamped_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    estop = 1'b0;
    cmd_valid_a = 1'b0; cmd_duty_a = 8'd0;
    cmd_valid_b = 1'b0; cmd_duty_b = 8'd0;
    cyc(3);

    // reset values
    chk("rst_duty", 9'(duty_a), 9'd0);
    chk("rst_busy", 9'(busy_a), 9'd0);
    chk("rst_at_target", 9'(at_a), 9'd1);
    chk("rst_clamped", 9'(clamped_a), 9'd0);
    chk("rst_cmd_ready", 9'(cmd_ready_a), 9'd1);

    // ramp 0 -> 100, STEP 10, ticks land on edges 4,8,...
    reset = 1'b0;
    cmd_valid_a = 1'b1; cmd_duty_a = 8'd100;
    cyc(1);
    cmd_valid_a = 1'b0;
    chk("up_cmd_ready", 9'(cmd_ready_a), 9'd1);
    cyc(1);
    chk("up_busy", 9'(busy_a), 9'd1);
    chk("up_duty_pre", 9'(duty_a), 9'd0);
    chk("up_at_target_pre", 9'(at_a), 9'd0);
    cyc(2);
    chk("up_duty_t1", 9'(duty_a), 9'd10);
    for (int i = 2; i <= 10; i++) begin
      cyc(4);
      chk($sformatf("up_duty_t%0d", i), 9'(duty_a), 9'(10 * i));
    end
    chk("up_done_busy", 9'(busy_a), 9'd0);
    chk("up_done_at_target", 9'(at_a), 9'd1);

    // direction flip: ramping 100 -> 200, at 120 command 115
    cmd_valid_a = 1'b1; cmd_duty_a = 8'd200;
    cyc(1);
    cmd_valid_a = 1'b0;
    cyc(3);
    chk("flip_duty_110", 9'(duty_a), 9'd110);
    cyc(4);
    chk("flip_duty_120", 9'(duty_a), 9'd120);
    cmd_valid_a = 1'b1; cmd_duty_a = 8'd115;
    cyc(1);
    cmd_valid_a = 1'b0;
    cyc(1);
    chk("flip_no_step", 9'(duty_a), 9'd120);
    chk("flip_busy", 9'(busy_a), 9'd1);
    cyc(1);
    chk("flip_hold", 9'(duty_a), 9'd120);
    cyc(1);
    chk("flip_duty_115", 9'(duty_a), 9'd115);
    chk("flip_at_target", 9'(at_a), 9'd1);
    chk("flip_busy_done", 9'(busy_a), 9'd0);

    // settle at 60, then ramp toward 80 and retarget to 37 on the tick cycle
    cmd_valid_a = 1'b1; cmd_duty_a = 8'd60;
    cyc(1);
    cmd_valid_a = 1'b0;
    cyc(23);
    chk("down_duty_60", 9'(duty_a), 9'd60);
    chk("down_at_target_60", 9'(at_a), 9'd1);
    cmd_valid_a = 1'b1; cmd_duty_a = 8'd80;
    cyc(1);
    cmd_valid_a = 1'b0;
    cyc(2);
    cmd_valid_a = 1'b1; cmd_duty_a = 8'd37;
    cyc(1);
    cmd_valid_a = 1'b0;
    chk("same_tick_old_target", 9'(duty_a), 9'd70);
    cyc(4);
    chk("retarget_60", 9'(duty_a), 9'd60);
    cyc(4);
    chk("retarget_50", 9'(duty_a), 9'd50);
    cyc(4);
    chk("retarget_40", 9'(duty_a), 9'd40);
    cyc(4);
    chk("retarget_37", 9'(duty_a), 9'd37);
    chk("retarget_at_target", 9'(at_a), 9'd1);
    chk("retarget_clamped", 9'(clamped_a), 9'd0);

    // clamp on b (STEP 50) alongside a ramp 0 -> 150 on a
    cyc(1);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cmd_valid_a = 1'b1; cmd_duty_a = 8'd150;
    cmd_valid_b = 1'b1; cmd_duty_b = 8'd255;
    cyc(1);
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    chk("clamp_flag", 9'(clamped_b), 9'd1);
    cyc(3);
    chk("clamp_duty_t1", 9'(duty_b), 9'd50);
    chk("pre_rst_a_t1", 9'(duty_a), 9'd10);
    for (int i = 2; i <= 9; i++) begin
      cyc(4);
      chk($sformatf("clamp_duty_t%0d", i), 9'(duty_b), (i * 50 > 250) ? 9'd250 : 9'(50 * i));
    end
    chk("clamp_at_target", 9'(at_b), 9'd1);
    chk("pre_rst_a_duty_90", 9'(duty_a), 9'd90);
    chk("pre_rst_a_busy", 9'(busy_a), 9'd1);

    // asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    chk("arst_duty", 9'(duty_a), 9'd0);
    chk("arst_busy", 9'(busy_a), 9'd0);
    chk("arst_at_target", 9'(at_a), 9'd1);
    chk("arst_clamped_b", 9'(clamped_b), 9'd0);
    chk("arst_duty_b", 9'(duty_b), 9'd0);

`ifdef DUTY_RAMP_ESTOP_EN
    cyc(1);
    reset = 1'b0;
    cmd_valid_b = 1'b1; cmd_duty_b = 8'd150;
    cyc(1);
    cmd_valid_b = 1'b0;
    cyc(11);
    chk("estop_pre_duty", 9'(duty_b), 9'd150);
    estop = 1'b1;
    cmd_valid_b = 1'b1; cmd_duty_b = 8'd200;
    cyc(1);
    chk("estop_duty", 9'(duty_b), 9'd0);
    chk("estop_cmd_ready", 9'(cmd_ready_b), 9'd0);
    chk("estop_busy", 9'(busy_b), 9'd0);
    chk("estop_at_target", 9'(at_b), 9'd1);
    cyc(2);
    estop = 1'b0;
    cmd_valid_b = 1'b0;
    chk("estop_ready_low", 9'(cmd_ready_b), 9'd0);
    cyc(1);
    chk("estop_ready_back", 9'(cmd_ready_b), 9'd1);
    chk("estop_release_duty", 9'(duty_b), 9'd0);
    cyc(8);
    chk("estop_stays_zero", 9'(duty_b), 9'd0);
    chk("estop_stays_idle", 9'(busy_b), 9'd0);
    chk("estop_clamped_held", 9'(clamped_b), 9'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
